tdm_demux4_rx: RTL and testbench
================================

// Module: tdm_demux4_rx
// PURPOSE
//  Receive side of the 4-channel time-division link whose transmit side uses the 4x1 channel mux.
//  Deserialises a 1-bit serial stream framed by a sync pulse into four slots of WIDTH bits.
//  Steers each slot to its own channel register, in the mux select order {s0,s1}: slot0->ch0 .. slot3->ch3.
//  Sits between the link input pins and the per-channel consumers. Raises a per-slot valid pulse and frame/sync status.
// PARAMETERS
//  WIDTH      8   bits per slot; legal range 2..32
//  MSB_FIRST  1   1: first bit of a slot is its MSB; 0: first bit is its LSB
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  sdi        in   1      serial data, one bit per clk
//  fsync      in   1      frame sync; high for one cycle, coincident with bit 0 of slot 0
//  ch0_data   out  WIDTH  slot 0 word, registered
//  ch1_data   out  WIDTH  slot 1 word, registered
//  ch2_data   out  WIDTH  slot 2 word, registered
//  ch3_data   out  WIDTH  slot 3 word, registered
//  ch_valid   out  4      bit k is a 1-cycle pulse when chk_data has just been updated
//  slot_idx   out  2      slot currently being received; 0 in HUNT
//  frame_done out  1      1-cycle pulse, coincident with ch_valid[3]
//  sync_err   out  1      1-cycle pulse when fsync is seen mid-frame
// BEHAVIOUR
//  Reset: all outputs 0, state=HUNT, bit_cnt=0, shift reg=0. Reset mid-frame discards the partial frame.
//  States:
//   - HUNT: ignore sdi until fsync=1. That cycle's sdi is bit 0 of slot 0; go to RECV with bit_cnt=1.
//   - RECV: each cycle, shift sdi in and increment bit_cnt.
//     On the last bit (bit_cnt==WIDTH-1) the full word {shift,sdi} is written to ch[slot_idx] at that edge.
//     ch_valid[slot_idx] is high the following cycle. Latency: last bit sampled -> data/valid visible 1 cycle later.
//     bit_cnt wraps to 0 and slot_idx increments.
//     After the last bit of slot 3: frame_done pulses with ch_valid[3] and the state returns to HUNT.
//  Back-to-back frames: fsync on the cycle right after slot 3's last bit is accepted, with no gap cycle.
//  Idle gaps between frames are legal; no error is raised.
//  Mid-frame fsync (RECV, any bit other than the expected frame start):
//   - sync_err pulses the next cycle.
//   - The partial slot is discarded; already-completed slots keep their new values.
//   - Reception restarts at slot 0 with the current sdi as bit 0.
//  fsync together with slot 3's last bit: the last bit completes slot 3 (valid + frame_done), sync_err pulses,
//  and the next cycle is bit 1 of slot 0.
//  chk_data holds its value until that slot is next written. ch_valid is one-hot or zero.
//  Bit order: MSB_FIRST=1 shifts left (first bit ends up in bit WIDTH-1); MSB_FIRST=0 shifts right.
//  bit_cnt is $clog2(WIDTH) bits wide; no combinational path from inputs to outputs.
// STRUCTURE
//  tdm_defs.vh (shared with the tx side): NUM_SLOTS=4, state encodings ST_HUNT/ST_RECV, slot index width 2.
//  Sub-module tdm_shift_rx: WIDTH shift register + bit counter + last_bit flag, MSB_FIRST-aware.
//  Top holds the FSM, slot counter, channel registers and the status pulses.
// TESTING
//  1 WIDTH=8, MSB_FIRST=1; fsync@c0, send A5,3C,FF,01 MSB-first
//    -> ch0..3 = A5,3C,FF,01; ch_valid = 0001@c8, 0010@c16, 0100@c24, 1000@c32; frame_done@c32.
//  2 Two frames back-to-back (fsync@c0 and c32), second frame 11,22,33,44
//    -> all four valids per frame, no sync_err, ch values 11,22,33,44 after c64.
//  3 fsync re-asserted at bit 3 of slot 2 (c19)
//    -> sync_err@c20; ch0/ch1 updated, ch2/ch3 unchanged; new frame decodes from c19.
//  4 rst asserted asynchronously mid-slot 1 and released, then a clean frame 5A,C3,0F,F0
//    -> all outputs 0 immediately on rst; next frame decodes correctly.
//  5 MSB_FIRST=0, slot 0 sent LSB-first as 1,0,1,0,0,1,0,1 -> ch0_data=A5.
//  6 sdi toggling with no fsync for 100 cycles -> no valid, frame_done or sync_err; slot_idx stays 0.

Source files
------------

// File: rtl/tdm_demux4_rx_pkg.sv
// Shared definitions for the 4-slot TDM receive path: slot count, FSM states, slot index helpers.
package tdm_demux4_rx_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input slot_t s);
    slot_onehot    = '0;
    slot_onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/tdm_demux4_rx_shift.sv
// Slot deserialiser: WIDTH-bit shift register with bit counter; word presents the completed slot
// combinationally on the last bit so the caller can register it at that same edge.
module tdm_demux4_rx_shift #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             start,
  input  logic             shift_en,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] loaded;
  logic [CW-1:0]    bit_cnt;

  // A start always lands sdi in the first-bit position with the rest cleared.
  always_comb begin
    shifted = '0;
    loaded  = '0;
    if (MSB_FIRST) begin
      shifted = {sreg[WIDTH-2:0], sdi};
      loaded  = {{(WIDTH-1){1'b0}}, sdi};
    end else begin
      shifted = {sdi, sreg[WIDTH-1:1]};
      loaded  = {sdi, {(WIDTH-1){1'b0}}};
    end
  end

  assign word     = shifted;
  assign last_bit = (bit_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      sreg    <= loaded;
      bit_cnt <= CW'(1);
    end else if (shift_en) begin
      sreg    <= shifted;
      bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4_rx.sv
// 4-channel TDM receiver: hunts for fsync, deserialises four WIDTH-bit slots into channel registers,
// and raises per-slot valid, frame_done and sync_err pulses. All outputs registered.
module tdm_demux4_rx
  import tdm_demux4_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             fsync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic [3:0]       ch_valid,
  output logic [1:0]       slot_idx,
  output logic             frame_done,
  output logic             sync_err
);

  state_t           state;
  logic [WIDTH-1:0] ch_q [NUM_SLOTS];
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             slot3_end;

  // Every fsync restarts the deserialiser with the current sdi as bit 0 of slot 0.
  tdm_demux4_rx_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .sdi      (sdi),
    .start    (fsync),
    .shift_en (state == ST_RECV),
    .word     (word),
    .last_bit (last_bit)
  );

  assign slot3_end = last_bit && (slot_idx == LAST_SLOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HUNT;
      slot_idx   <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      ch_q       <= '{default: '0};
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (fsync) begin
            state    <= ST_RECV;
            slot_idx <= '0;
          end
        end
        ST_RECV: begin
          if (fsync && !slot3_end) begin
            // Partial slot is dropped; completed slots of this frame keep their new values.
            sync_err <= 1'b1;
            slot_idx <= '0;
          end else if (last_bit) begin
            ch_q[slot_idx] <= word;
            ch_valid       <= slot_onehot(slot_idx);
            if (slot_idx == LAST_SLOT) begin
              frame_done <= 1'b1;
              slot_idx   <= '0;
              // fsync on slot 3's last bit: that bit also seeds the next frame.
              if (fsync) sync_err <= 1'b1;
              else       state    <= ST_HUNT;
            end else begin
              slot_idx <= slot_idx + 2'd1;
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  assign ch0_data = ch_q[0];
  assign ch1_data = ch_q[1];
  assign ch2_data = ch_q[2];
  assign ch3_data = ch_q[3];

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Bench for tdm_demux4_rx: MSB-first and LSB-first instances fed the same stream, checked against a bit-position model.
module tb_tdm_demux4_rx;

  localparam int W  = 8;
  localparam int FB = 4 * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sdi = 1'b0;
  logic fsync = 1'b0;

  logic [W-1:0] m_ch0, m_ch1, m_ch2, m_ch3, l_ch0, l_ch1, l_ch2, l_ch3;
  logic [3:0]   m_valid, l_valid;
  logic [1:0]   m_slot, l_slot;
  logic         m_fd, l_fd, m_se, l_se;

  tdm_demux4_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sdi(sdi), .fsync(fsync),
    .ch0_data(m_ch0), .ch1_data(m_ch1), .ch2_data(m_ch2), .ch3_data(m_ch3),
    .ch_valid(m_valid), .slot_idx(m_slot), .frame_done(m_fd), .sync_err(m_se)
  );

  tdm_demux4_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sdi(sdi), .fsync(fsync),
    .ch0_data(l_ch0), .ch1_data(l_ch1), .ch2_data(l_ch2), .ch3_data(l_ch3),
    .ch_valid(l_valid), .slot_idx(l_slot), .frame_done(l_fd), .sync_err(l_se)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: p = number of bits received in the current frame, -1 while hunting.
  int           p;
  logic [W-1:0] bitbuf;
  logic [W-1:0] em [4];
  logic [W-1:0] el [4];
  logic [3:0]   ev;
  logic [1:0]   es;
  logic         efd, ese;

  logic [FB+7:0] act_m, act_l, exp_m, exp_l;
  assign act_m = {m_ch3, m_ch2, m_ch1, m_ch0, m_valid, m_slot, m_fd, m_se};
  assign act_l = {l_ch3, l_ch2, l_ch1, l_ch0, l_valid, l_slot, l_fd, l_se};
  assign exp_m = {em[3], em[2], em[1], em[0], ev, es, efd, ese};
  assign exp_l = {el[3], el[2], el[1], el[0], ev, es, efd, ese};

  logic qs[$];
  logic qf[$];

  task automatic model_reset();
    p = -1;
    bitbuf = '0;
    for (int k = 0; k < 4; k++) begin
      em[k] = '0;
      el[k] = '0;
    end
    ev = '0; es = '0; efd = 1'b0; ese = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic f);
    int k;
    ev = '0; efd = 1'b0; ese = 1'b0;
    if (p < 0) begin
      if (f) begin
        bitbuf[0] = s;
        p = 1;
      end
    end else if (f && p != FB - 1) begin
      ese = 1'b1;
      bitbuf[0] = s;
      p = 1;
    end else begin
      bitbuf[p % W] = s;
      if (p % W == W - 1) begin
        k = p / W;
        for (int i = 0; i < W; i++) begin
          em[k][W-1-i] = bitbuf[i];
          el[k][i]     = bitbuf[i];
        end
        ev[k] = 1'b1;
      end
      p++;
      if (p == FB) begin
        efd = 1'b1;
        if (f) begin
          ese = 1'b1;
          bitbuf[0] = s;
          p = 1;
        end else begin
          p = -1;
        end
      end
    end
    es = (p < 0) ? 2'd0 : 2'(p / W);
  endtask

  task automatic cyc(input logic s, input logic f);
    @(negedge clk);
    sdi = s;
    fsync = f;
    model_step(s, f);
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [FB-1:0] fr, input bit with_sync);
    for (int i = 0; i < FB; i++) begin
      qs.push_back(fr[FB-1-i]);
      qf.push_back(with_sync && i == 0);
    end
  endtask

  task automatic push_idle(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      qs.push_back(noisy ? 1'($urandom) : 1'b0);
      qf.push_back(1'b0);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({act_m, act_l} !== '0) begin
      errors++;
      $display("FAIL reset_state dut=%h/%h want=0", act_m, act_l);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    checks++;
    if ({act_m, act_l} !== {exp_m, exp_l}) begin
      errors++;
      $display("FAIL reset_release dut=%h/%h model=%h/%h", act_m, act_l, exp_m, exp_l);
    end
  endtask

  task automatic test_frame();
    qs.delete(); qf.delete();
    push_frame({8'hA5, 8'h3C, 8'hFF, 8'h01}, 1'b1);
    push_idle(2, 1'b0);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL frame c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
      if (c == 7 || c == 15 || c == 23 || c == 31) begin
        checks++;
        if (m_valid !== 4'(1 << (c / 8)) || m_fd !== (c == 31)) begin
          errors++;
          $display("FAIL frame_valid c%0d valid=%b fd=%b", c + 1, m_valid, m_fd);
        end
      end
    end
    checks++;
    if ({m_ch0, m_ch1, m_ch2, m_ch3} !== 32'hA53CFF01) begin
      errors++;
      $display("FAIL frame_words got=%h want=A53CFF01", {m_ch0, m_ch1, m_ch2, m_ch3});
    end
    checks++;
    if (l_ch0 !== 8'hA5 || l_ch3 !== 8'h80) begin
      errors++;
      $display("FAIL lsb_first ch0=%h ch3=%h want A5/80", l_ch0, l_ch3);
    end
  endtask

  task automatic test_back_to_back();
    int nse = 0;
    int nfd = 0;
    qs.delete(); qf.delete();
    push_frame($urandom, 1'b1);
    push_frame({8'h11, 8'h22, 8'h33, 8'h44}, 1'b1);
    push_idle(1, 1'b0);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      nse += int'(m_se);
      nfd += int'(m_fd);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL b2b c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
    end
    checks++;
    if (nse != 0 || nfd != 2 || {m_ch0, m_ch1, m_ch2, m_ch3} !== 32'h11223344) begin
      errors++;
      $display("FAIL b2b_summary sync_err=%0d frames=%0d words=%h want 0/2/11223344",
               nse, nfd, {m_ch0, m_ch1, m_ch2, m_ch3});
    end
  endtask

  task automatic test_midframe_sync();
    qs.delete(); qf.delete();
    push_frame({8'h66, 8'h77, 8'h88, 8'h99}, 1'b1);
    repeat (FB - 19) begin
      void'(qs.pop_back());
      void'(qf.pop_back());
    end
    push_frame($urandom, 1'b1);
    push_idle(2, 1'b0);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL midsync c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
      if (c == 19) begin
        checks++;
        if (m_se !== 1'b1 || {m_ch0, m_ch1, m_ch2, m_ch3} !== 32'h66773344 || m_slot !== 2'd0) begin
          errors++;
          $display("FAIL midsync_err se=%b words=%h slot=%0d want 1/66773344/0",
                   m_se, {m_ch0, m_ch1, m_ch2, m_ch3}, m_slot);
        end
      end
    end
  endtask

  task automatic test_sync_on_last_bit();
    qs.delete(); qf.delete();
    push_frame($urandom, 1'b1);
    qf[FB-1] = 1'b1;
    push_frame($urandom, 1'b0);
    void'(qs.pop_front());
    for (int i = 0; i < FB - 1; i++) void'(qs.pop_back());
    for (int i = 0; i < FB - 1; i++) qs.push_back(1'($urandom));
    qf = qf[0:2*FB-2];
    push_idle(2, 1'b0);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL lastbit_sync c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
      if (c == FB - 1) begin
        checks++;
        if (m_valid !== 4'b1000 || m_fd !== 1'b1 || m_se !== 1'b1) begin
          errors++;
          $display("FAIL lastbit_pulses valid=%b fd=%b se=%b want 1000/1/1", m_valid, m_fd, m_se);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    qs.delete(); qf.delete();
    push_frame($urandom, 1'b1);
    for (int c = 0; c < 12; c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL arst_pre c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({act_m, act_l} !== '0) begin
      errors++;
      $display("FAIL arst_immediate dut=%h/%h want=0", act_m, act_l);
    end
    sdi = 1'b0;
    fsync = 1'b0;
    @(negedge clk) rst = 1'b0;
    qs.delete(); qf.delete();
    push_frame({8'h5A, 8'hC3, 8'h0F, 8'hF0}, 1'b1);
    push_idle(2, 1'b0);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL arst_post c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
    end
    checks++;
    if ({m_ch0, m_ch1, m_ch2, m_ch3} !== 32'h5AC30FF0) begin
      errors++;
      $display("FAIL arst_words got=%h want=5AC30FF0", {m_ch0, m_ch1, m_ch2, m_ch3});
    end
  endtask

  task automatic test_idle_noise();
    qs.delete(); qf.delete();
    push_idle(100, 1'b1);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if (m_valid !== 4'd0 || l_valid !== 4'd0 || m_fd !== 1'b0 || m_se !== 1'b0 || m_slot !== 2'd0
          || {act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL idle c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
    end
  endtask

  task automatic test_random();
    int base;
    qs.delete(); qf.delete();
    for (int n = 0; n < 12; n++) begin
      push_idle($urandom_range(0, 3), 1'b1);
      base = qs.size();
      push_frame($urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) qf[base + $urandom_range(1, FB - 1)] = 1'b1;
    end
    push_idle(2, 1'b0);
    for (int c = 0; c < qs.size(); c++) begin
      cyc(qs[c], qf[c]);
      checks++;
      if ({act_m, act_l} !== {exp_m, exp_l}) begin
        errors++;
        $display("FAIL random c%0d dut=%h/%h model=%h/%h", c + 1, act_m, act_l, exp_m, exp_l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_midframe_sync();
    test_sync_on_last_bit();
    test_async_reset();
    test_idle_noise();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
